// File: rtl/multi_alarm_clock_pkg.sv
// Shared BCD time types, edit-field encodings and time arithmetic helpers
// for the multi-alarm clock core.
package multi_alarm_clock_pkg;

   typedef logic [7:0] bcd8_t;

   typedef struct packed {
      bcd8_t hh;
      bcd8_t mm;
   } hhmm_t;

   typedef struct packed {
      bcd8_t hh;
      bcd8_t mm;
      bcd8_t ss;
   } hhmmss_t;

   typedef struct packed {
      bcd8_t hh;
      logic  pm;
   } hh12_t;

   typedef enum logic [1:0] {
      FieldNone = 2'd0,
      FieldHour = 2'd1,
      FieldMin  = 2'd2,
      FieldSec  = 2'd3
   } edit_field_e;

   localparam bcd8_t MaxHour = 8'h23;
   localparam bcd8_t MaxMin  = 8'h59;
   localparam bcd8_t MaxSec  = 8'h59;

   function automatic logic [6:0] bcd_to_bin(bcd8_t v);
      return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
   endfunction

   function automatic bcd8_t bin_to_bcd(logic [6:0] b);
      return {4'(b / 7'd10), 4'(b % 7'd10)};
   endfunction

   function automatic bcd8_t bcd_inc_wrap(bcd8_t val, bcd8_t max);
      bcd8_t r;
      if (val == max) begin
         r = 8'h00;
      end else if (val[3:0] == 4'd9) begin
         r = {val[7:4] + 4'd1, 4'd0};
      end else begin
         r = {val[7:4], val[3:0] + 4'd1};
      end
      return r;
   endfunction

   // n is at most 59, so at most one hour carry is possible.
   function automatic hhmm_t hhmm_add_min(hhmm_t t, logic [6:0] n);
      hhmm_t      r;
      logic [6:0] m;
      logic [6:0] h;
      m = bcd_to_bin(t.mm) + n;
      h = bcd_to_bin(t.hh);
      if (m >= 7'd60) begin
         m = m - 7'd60;
         h = (h == 7'd23) ? 7'd0 : h + 7'd1;
      end
      r.hh = bin_to_bcd(h);
      r.mm = bin_to_bcd(m);
      return r;
   endfunction

   function automatic hh12_t to_12h(bcd8_t hh);
      hh12_t      r;
      logic [6:0] h;
      h    = bcd_to_bin(hh);
      r.pm = (h >= 7'd12);
      if (h == 7'd0) begin
         r.hh = 8'h12;
      end else if (h > 7'd12) begin
         r.hh = bin_to_bcd(h - 7'd12);
      end else begin
         r.hh = hh;
      end
      return r;
   endfunction

endpackage

// File: rtl/multi_alarm_clock_bcd_time_counter.sv
// BCD hh:mm:ss time-of-day counter with hold and per-field increment. The
// minute-rollover strobe and post-edge hh:mm feed the alarm compare.
module multi_alarm_clock_bcd_time_counter
   import multi_alarm_clock_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        tick_i,
   input  logic        hold_i,
   input  logic        inc_i,
   input  edit_field_e field_i,
   output hhmmss_t     time_o,
   output hhmm_t       next_hhmm_o,
   output logic        min_roll_o
);

   hhmmss_t time_q;
   hhmmss_t time_d;

   always_comb begin
      time_d     = time_q;
      min_roll_o = 1'b0;
      if (tick_i && !hold_i) begin
         time_d.ss = bcd_inc_wrap(time_q.ss, MaxSec);
         if (time_q.ss == MaxSec) begin
            min_roll_o = 1'b1;
            time_d.mm  = bcd_inc_wrap(time_q.mm, MaxMin);
            if (time_q.mm == MaxMin) begin
               time_d.hh = bcd_inc_wrap(time_q.hh, MaxHour);
            end
         end
      end
      // Field edits never carry into the next field.
      if (inc_i) begin
         case (field_i)
            FieldHour: time_d.hh = bcd_inc_wrap(time_q.hh, MaxHour);
            FieldMin:  time_d.mm = bcd_inc_wrap(time_q.mm, MaxMin);
            FieldSec:  time_d.ss = 8'h00;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         time_q <= '0;
      end else begin
         time_q <= time_d;
      end
   end

   assign time_o      = time_q;
   assign next_hhmm_o = {time_d.hh, time_d.mm};

endmodule

// File: rtl/multi_alarm_clock.sv
// 24 h BCD time-of-day core with N minute alarms, snooze, ring timeout and
// a registered 12/24 h display of the time or the selected alarm.
module multi_alarm_clock
   import multi_alarm_clock_pkg::*;
#(
   parameter int unsigned N_ALARMS   = 4,
   parameter int unsigned SNOOZE_MIN = 5,
   parameter int unsigned RING_SEC   = 60
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                TICK,
   input  logic                MODE_12H,
   input  logic [2:0]          EDIT_SEL,
   input  logic [1:0]          EDIT_FIELD,
   input  logic                INC,
   input  logic                AL_TOGGLE,
   input  logic                SNOOZE,
   input  logic                STOP,
   output logic [23:0]         DISP_BCD,
   output logic                PM,
   output logic [N_ALARMS-1:0] ALARM_EN,
   output logic [N_ALARMS-1:0] RINGING,
   output logic                BUZZ
);

   edit_field_e field;
   logic        sel_time;
   logic        hold;
   hhmmss_t     time_q;
   hhmm_t       cur_hhmm;
   hhmm_t       next_hhmm;
   hhmm_t       snooze_at;
   logic        min_roll;
   hhmm_t       al_hhmm [N_ALARMS];

   assign field     = edit_field_e'(EDIT_FIELD);
   assign sel_time  = (EDIT_SEL == 3'd0);
   assign hold      = sel_time && (field != FieldNone);
   assign cur_hhmm  = {time_q.hh, time_q.mm};
   assign snooze_at = hhmm_add_min(cur_hhmm, 7'(SNOOZE_MIN));

   multi_alarm_clock_bcd_time_counter u_time (
      .clk_i       (CLK),
      .rst_i       (RESET),
      .tick_i      (TICK),
      .hold_i      (hold),
      .inc_i       (INC && sel_time),
      .field_i     (field),
      .time_o      (time_q),
      .next_hhmm_o (next_hhmm),
      .min_roll_o  (min_roll)
   );

   for (genvar k = 0; k < N_ALARMS; k++) begin : g_alarm
      logic       sel;
      hhmm_t      hhmm_q, hhmm_d;
      hhmm_t      snz_hhmm_q, snz_hhmm_d;
      hhmm_t      target;
      logic       en_q, en_d;
      logic       ring_q, ring_d;
      logic       snz_q, snz_d;
      logic [7:0] cnt_q, cnt_d;

      assign sel    = (EDIT_SEL == 3'(k + 1));
      assign target = snz_q ? snz_hhmm_q : hhmm_q;

      // Later statements take priority: STOP/SNOOZE act on the old RINGING,
      // a fresh match re-arms, and disabling overrides everything.
      always_comb begin
         hhmm_d     = hhmm_q;
         snz_hhmm_d = snz_hhmm_q;
         en_d       = en_q;
         ring_d     = ring_q;
         snz_d      = snz_q;
         cnt_d      = cnt_q;
         if (INC && sel) begin
            if (field == FieldHour) begin
               hhmm_d.hh = bcd_inc_wrap(hhmm_q.hh, MaxHour);
            end else if (field == FieldMin) begin
               hhmm_d.mm = bcd_inc_wrap(hhmm_q.mm, MaxMin);
            end
         end
         if (ring_q && TICK) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               ring_d = 1'b0;
            end
         end
         if (STOP) begin
            ring_d = 1'b0;
            snz_d  = 1'b0;
         end else if (SNOOZE && ring_q) begin
            ring_d     = 1'b0;
            snz_d      = 1'b1;
            snz_hhmm_d = snooze_at;
         end
         if (en_q && min_roll && (next_hhmm == target)) begin
            ring_d = 1'b1;
            cnt_d  = 8'(RING_SEC);
            snz_d  = 1'b0;
         end
         if (AL_TOGGLE && sel) begin
            en_d = !en_q;
            if (en_q) begin
               ring_d = 1'b0;
               snz_d  = 1'b0;
               cnt_d  = 8'd0;
            end
         end
      end

      always_ff @(posedge CLK) begin
         if (RESET) begin
            hhmm_q     <= '0;
            snz_hhmm_q <= '0;
            en_q       <= 1'b0;
            ring_q     <= 1'b0;
            snz_q      <= 1'b0;
            cnt_q      <= 8'd0;
         end else begin
            hhmm_q     <= hhmm_d;
            snz_hhmm_q <= snz_hhmm_d;
            en_q       <= en_d;
            ring_q     <= ring_d;
            snz_q      <= snz_d;
            cnt_q      <= cnt_d;
         end
      end

      assign al_hhmm[k]  = hhmm_q;
      assign ALARM_EN[k] = en_q;
      assign RINGING[k]  = ring_q;
   end

   hhmmss_t     src;
   hh12_t       h12;
   logic [23:0] disp_d, disp_q;
   logic        pm_d, pm_q, buzz_q;

   always_comb begin
      src = time_q;
      for (int k = 0; k < N_ALARMS; k++) begin
         if (EDIT_SEL == 3'(k + 1)) begin
            src = {al_hhmm[k], 8'h00};
         end
      end
      h12    = to_12h(src.hh);
      disp_d = src;
      pm_d   = 1'b0;
      if (MODE_12H) begin
         disp_d = {h12.hh, src.mm, src.ss};
         pm_d   = h12.pm;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         disp_q <= 24'h000000;
         pm_q   <= 1'b0;
         buzz_q <= 1'b0;
      end else begin
         disp_q <= disp_d;
         pm_q   <= pm_d;
         buzz_q <= |RINGING;
      end
   end

   assign DISP_BCD = disp_q;
   assign PM       = pm_q;
   assign BUZZ     = buzz_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Bench for multi_alarm_clock: directed scenarios plus random stimulus, all
// checked against an integer seconds/minutes-of-day model of the clock.
module tb_multi_alarm_clock;

   localparam int NA  = 4;
   localparam int SNZ = 5;
   localparam int RS  = 60;

   logic          CLK = 1'b0;
   logic          RESET, TICK, MODE_12H, INC, AL_TOGGLE, SNOOZE, STOP;
   logic [2:0]    EDIT_SEL;
   logic [1:0]    EDIT_FIELD;
   logic [23:0]   DISP_BCD;
   logic          PM, BUZZ;
   logic [NA-1:0] ALARM_EN, RINGING;

   multi_alarm_clock #(
      .N_ALARMS   (NA),
      .SNOOZE_MIN (SNZ),
      .RING_SEC   (RS)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .TICK       (TICK),
      .MODE_12H   (MODE_12H),
      .EDIT_SEL   (EDIT_SEL),
      .EDIT_FIELD (EDIT_FIELD),
      .INC        (INC),
      .AL_TOGGLE  (AL_TOGGLE),
      .SNOOZE     (SNOOZE),
      .STOP       (STOP),
      .DISP_BCD   (DISP_BCD),
      .PM         (PM),
      .ALARM_EN   (ALARM_EN),
      .RINGING    (RINGING),
      .BUZZ       (BUZZ)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   // Model state: time as seconds of day, alarms as minutes of day.
   int          secs;
   int          al_min [NA];
   int          snz_min [NA];
   int          cnt [NA];
   bit          m_en [NA];
   bit          m_ring [NA];
   bit          m_snz [NA];
   logic [23:0] exp_disp;
   logic        exp_pm, exp_buzz;

   function automatic logic [7:0] to_bcd(int v);
      return 8'((v / 10) * 16 + v % 10);
   endfunction

   function automatic logic [NA-1:0] ring_vec();
      logic [NA-1:0] v = '0;
      for (int k = 0; k < NA; k++) v[k] = m_ring[k];
      return v;
   endfunction

   function automatic logic [NA-1:0] en_vec();
      logic [NA-1:0] v = '0;
      for (int k = 0; k < NA; k++) v[k] = m_en[k];
      return v;
   endfunction

   task automatic model_edge();
      int h, m, s, sel, now_min;
      bit roll;
      int p_al [NA];
      int p_snzmin [NA];
      bit p_en [NA];
      bit p_ring [NA];
      bit p_snz [NA];
      if (RESET) begin
         secs = 0;
         for (int k = 0; k < NA; k++) begin
            al_min[k] = 0; snz_min[k] = 0; cnt[k] = 0;
            m_en[k] = 0; m_ring[k] = 0; m_snz[k] = 0;
         end
         exp_disp = '0; exp_pm = 0; exp_buzz = 0;
         return;
      end
      sel = int'(EDIT_SEL);
      if (sel >= 1 && sel <= NA) begin
         h = al_min[sel-1] / 60; m = al_min[sel-1] % 60; s = 0;
      end else begin
         h = secs / 3600; m = (secs / 60) % 60; s = secs % 60;
      end
      exp_pm = 0;
      if (MODE_12H) begin
         exp_pm = (h >= 12);
         h = (h % 12 == 0) ? 12 : h % 12;
      end
      exp_disp = {to_bcd(h), to_bcd(m), to_bcd(s)};
      exp_buzz = 0;
      for (int k = 0; k < NA; k++) if (m_ring[k]) exp_buzz = 1;
      now_min = secs / 60;
      p_al = al_min; p_snzmin = snz_min; p_en = m_en; p_ring = m_ring; p_snz = m_snz;
      roll = 0;
      if (TICK && !(sel == 0 && EDIT_FIELD != 2'd0)) begin
         secs = (secs + 1) % 86400;
         roll = (secs % 60 == 0);
      end
      if (INC && sel == 0) begin
         case (EDIT_FIELD)
            2'd1: secs = ((secs / 3600 + 1) % 24) * 3600 + secs % 3600;
            2'd2: secs = (secs / 3600) * 3600 + (((secs / 60) % 60 + 1) % 60) * 60 + secs % 60;
            2'd3: secs = secs - secs % 60;
            default: ;
         endcase
      end
      for (int k = 0; k < NA; k++) begin
         if (INC && sel == k + 1) begin
            if (EDIT_FIELD == 2'd1) al_min[k] = ((p_al[k] / 60 + 1) % 24) * 60 + p_al[k] % 60;
            else if (EDIT_FIELD == 2'd2) al_min[k] = (p_al[k] / 60) * 60 + (p_al[k] % 60 + 1) % 60;
         end
         if (p_ring[k] && TICK) begin
            cnt[k]--;
            if (cnt[k] == 0) m_ring[k] = 0;
         end
         if (STOP) begin
            m_ring[k] = 0; m_snz[k] = 0;
         end else if (SNOOZE && p_ring[k]) begin
            m_ring[k] = 0; m_snz[k] = 1; snz_min[k] = (now_min + SNZ) % 1440;
         end
         if (p_en[k] && roll && (secs / 60 == (p_snz[k] ? p_snzmin[k] : p_al[k]))) begin
            m_ring[k] = 1; cnt[k] = RS; m_snz[k] = 0;
         end
         if (AL_TOGGLE && sel == k + 1) begin
            if (p_en[k]) begin
               m_en[k] = 0; m_ring[k] = 0; m_snz[k] = 0; cnt[k] = 0;
            end else begin
               m_en[k] = 1;
            end
         end
      end
   endtask

   task automatic step(input bit tick, input bit inc, input bit tog, input bit snz,
                       input bit stop);
      TICK = tick; INC = inc; AL_TOGGLE = tog; SNOOZE = snz; STOP = stop;
      @(posedge CLK);
      model_edge();
      #1;
      TICK = 0; INC = 0; AL_TOGGLE = 0; SNOOZE = 0; STOP = 0;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      EDIT_SEL = 3'd0;
      EDIT_FIELD = 2'd1;
      for (int i = 0; i < 24 && secs / 3600 != h; i++) step(0, 1, 0, 0, 0);
      EDIT_FIELD = 2'd2;
      for (int i = 0; i < 60 && (secs / 60) % 60 != m; i++) step(0, 1, 0, 0, 0);
      EDIT_FIELD = 2'd3;
      step(0, 1, 0, 0, 0);
      EDIT_FIELD = 2'd0;
      for (int i = 0; i < s; i++) step(1, 0, 0, 0, 0);
   endtask

   task automatic set_alarm(input int k, input int h, input int m, input bit en);
      EDIT_SEL = 3'(k + 1);
      EDIT_FIELD = 2'd1;
      for (int i = 0; i < 24 && al_min[k] / 60 != h; i++) step(0, 1, 0, 0, 0);
      EDIT_FIELD = 2'd2;
      for (int i = 0; i < 60 && al_min[k] % 60 != m; i++) step(0, 1, 0, 0, 0);
      EDIT_FIELD = 2'd0;
      if (m_en[k] != en) step(0, 0, 1, 0, 0);
      EDIT_SEL = 3'd0;
   endtask

   task automatic tick_until(input int target, input int max);
      for (int i = 0; i < max && secs != target; i++) step(1, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      RESET = 1;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      RESET = 0;
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (DISP_BCD !== 24'h000000 || PM !== 1'b0) begin
         n_err++; $display("FAIL reset_disp: DISP=%h PM=%b want 000000 0", DISP_BCD, PM);
      end
      n_vec++;
      if (RINGING !== '0 || ALARM_EN !== '0 || BUZZ !== 1'b0) begin
         n_err++;
         $display("FAIL reset_alarm: RING=%b EN=%b BUZZ=%b want 0", RINGING, ALARM_EN, BUZZ);
      end
   endtask

   task automatic test_rollover();
      set_time(23, 59, 58);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      n_vec++;
      if (DISP_BCD !== 24'h235959) begin
         n_err++; $display("FAIL pre_midnight: DISP=%h want 235959", DISP_BCD);
      end
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (DISP_BCD !== 24'h000000 || DISP_BCD !== exp_disp || PM !== 1'b0) begin
         n_err++; $display("FAIL midnight: DISP=%h PM=%b want 000000 0", DISP_BCD, PM);
      end
   endtask

   task automatic test_alarm_ring();
      set_alarm(0, 7, 30, 1);
      set_time(7, 29, 59);
      step(1, 0, 0, 0, 0);
      n_vec++;
      if (RINGING !== 4'b0001 || BUZZ !== 1'b0) begin
         n_err++; $display("FAIL ring_0730: RING=%b BUZZ=%b want 0001 0", RINGING, BUZZ);
      end
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (BUZZ !== 1'b1) begin
         n_err++; $display("FAIL buzz_lag: BUZZ=%b want 1", BUZZ);
      end
      for (int i = 0; i < RS - 1; i++) step(1, 0, 0, 0, 0);
      n_vec++;
      if (RINGING !== 4'b0001) begin
         n_err++; $display("FAIL ring_59: RING=%b want 0001", RINGING);
      end
      step(1, 0, 0, 0, 0);
      n_vec++;
      if (RINGING !== 4'b0000 || RINGING !== ring_vec()) begin
         n_err++; $display("FAIL ring_timeout: RING=%b want 0000", RINGING);
      end
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (BUZZ !== 1'b0) begin
         n_err++; $display("FAIL buzz_off: BUZZ=%b want 0", BUZZ);
      end
   endtask

   task automatic test_snooze();
      set_alarm(0, 23, 58, 1);
      set_time(23, 57, 59);
      step(1, 0, 0, 0, 0);
      n_vec++;
      if (RINGING !== 4'b0001) begin
         n_err++; $display("FAIL ring_2358: RING=%b want 0001", RINGING);
      end
      step(0, 0, 0, 1, 0);
      n_vec++;
      if (RINGING !== 4'b0000 || ALARM_EN !== 4'b0001) begin
         n_err++; $display("FAIL snooze_clr: RING=%b EN=%b want 0000 0001", RINGING, ALARM_EN);
      end
      tick_until(23 * 3600 + 59 * 60, 200);
      n_vec++;
      if (RINGING !== 4'b0000) begin
         n_err++; $display("FAIL no_ring_2359: RING=%b want 0000", RINGING);
      end
      tick_until(3 * 60, 400);
      n_vec++;
      if (RINGING !== 4'b0001) begin
         n_err++; $display("FAIL snooze_ring_0003: RING=%b want 0001", RINGING);
      end
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (DISP_BCD !== 24'h000300) begin
         n_err++; $display("FAIL snooze_time: DISP=%h want 000300", DISP_BCD);
      end
      step(0, 0, 0, 0, 1);
   endtask

   task automatic test_back_to_back();
      set_alarm(0, 23, 58, 0);
      set_alarm(1, 12, 0, 1);
      set_alarm(2, 12, 0, 1);
      set_time(11, 59, 59);
      step(1, 0, 0, 0, 0);
      n_vec++;
      if (RINGING !== 4'b0110 || ALARM_EN !== 4'b0110) begin
         n_err++; $display("FAIL dual_ring: RING=%b EN=%b want 0110 0110", RINGING, ALARM_EN);
      end
      step(0, 0, 0, 1, 1);
      n_vec++;
      if (RINGING !== 4'b0000) begin
         n_err++; $display("FAIL stop_snooze: RING=%b want 0000", RINGING);
      end
      tick_until(12 * 3600 + 5 * 60, 400);
      n_vec++;
      if (RINGING !== 4'b0000 || RINGING !== ring_vec()) begin
         n_err++; $display("FAIL no_ring_1205: RING=%b want 0000", RINGING);
      end
   endtask

   task automatic test_edit_no_ring();
      set_alarm(3, 13, 10, 1);
      set_time(13, 9, 5);
      EDIT_FIELD = 2'd2;
      step(0, 1, 0, 0, 0);
      EDIT_FIELD = 2'd0;
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (RINGING !== 4'b0000 || DISP_BCD !== 24'h131005) begin
         n_err++; $display("FAIL edit_no_ring: RING=%b DISP=%h want 0000 131005", RINGING, DISP_BCD);
      end
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      n_vec++;
      if (RINGING !== 4'b0000) begin
         n_err++; $display("FAIL edit_ticks: RING=%b want 0000", RINGING);
      end
      EDIT_SEL = 3'd4;
      EDIT_FIELD = 2'd2;
      step(0, 1, 0, 0, 0);
      EDIT_FIELD = 2'd0;
      EDIT_SEL = 3'd0;
      tick_until(13 * 3600 + 11 * 60, 100);
      n_vec++;
      if (RINGING !== 4'b1000 || ALARM_EN !== 4'b1110) begin
         n_err++; $display("FAIL ring_1311: RING=%b EN=%b want 1000 1110", RINGING, ALARM_EN);
      end
      EDIT_SEL = 3'd4;
      step(0, 0, 1, 0, 0);
      EDIT_SEL = 3'd0;
      n_vec++;
      if (RINGING !== 4'b0000 || ALARM_EN !== 4'b0110) begin
         n_err++; $display("FAIL toggle_off: RING=%b EN=%b want 0000 0110", RINGING, ALARM_EN);
      end
   endtask

   task automatic test_12h();
      MODE_12H = 1;
      set_time(0, 15, 0);
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (DISP_BCD !== 24'h121500 || PM !== 1'b0) begin
         n_err++; $display("FAIL h12_0015: DISP=%h PM=%b want 121500 0", DISP_BCD, PM);
      end
      set_time(12, 0, 0);
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (DISP_BCD !== 24'h120000 || PM !== 1'b1) begin
         n_err++; $display("FAIL h12_1200: DISP=%h PM=%b want 120000 1", DISP_BCD, PM);
      end
      set_time(13, 45, 0);
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (DISP_BCD !== 24'h014500 || PM !== 1'b1) begin
         n_err++; $display("FAIL h12_1345: DISP=%h PM=%b want 014500 1", DISP_BCD, PM);
      end
      EDIT_SEL = 3'd2;
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (DISP_BCD !== 24'h120000 || PM !== 1'b1) begin
         n_err++; $display("FAIL h12_alarm1: DISP=%h PM=%b want 120000 1", DISP_BCD, PM);
      end
      EDIT_SEL = 3'd0;
      MODE_12H = 0;
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (DISP_BCD !== 24'h134500 || PM !== 1'b0) begin
         n_err++; $display("FAIL h24_1345: DISP=%h PM=%b want 134500 0", DISP_BCD, PM);
      end
   endtask

   task automatic test_random();
      int nm;
      nm = (secs / 60 + 1) % 1440;
      set_alarm(0, nm / 60, nm % 60, 1);
      nm = (secs / 60 + 3) % 1440;
      set_alarm(3, nm / 60, nm % 60, 1);
      for (int i = 0; i < 1500; i++) begin
         EDIT_SEL   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
         EDIT_FIELD = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         MODE_12H   = 1'($urandom_range(0, 1));
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
              $urandom_range(0, 63) == 0);
         n_vec++;
         if (DISP_BCD !== exp_disp || PM !== exp_pm || BUZZ !== exp_buzz) begin
            n_err++;
            $display("FAIL rand_disp[%0d]: DISP=%h PM=%b BUZZ=%b want %h %b %b", i, DISP_BCD,
                     PM, BUZZ, exp_disp, exp_pm, exp_buzz);
         end
         n_vec++;
         if (RINGING !== ring_vec() || ALARM_EN !== en_vec()) begin
            n_err++;
            $display("FAIL rand_alarm[%0d]: RING=%b EN=%b want %b %b", i, RINGING, ALARM_EN,
                     ring_vec(), en_vec());
         end
      end
      EDIT_SEL = 3'd0; EDIT_FIELD = 2'd0; MODE_12H = 0;
   endtask

   initial begin
      RESET = 0; TICK = 0; MODE_12H = 0; INC = 0; AL_TOGGLE = 0; SNOOZE = 0; STOP = 0;
      EDIT_SEL = 3'd0; EDIT_FIELD = 2'd0;
      test_reset();
      test_rollover();
      test_alarm_ring();
      test_snooze();
      test_back_to_back();
      test_edit_no_ring();
      test_12h();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
